// File: rtl/fetch_unit_pkg.sv
// Shared fetch/branch definitions: default widths, branch opcodes, fetch FSM encoding and a counter-width helper.
package fetch_unit_pkg;

    localparam int PC_W_DEF    = 19;
    localparam int INSTR_W_DEF = 32;

    localparam logic [4:0] OPC_BEQ = 5'b01010;
    localparam logic [4:0] OPC_BNE = 5'b01011;
    localparam logic [4:0] OPC_JMP = 5'b01100;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: branch redirect in, imem request/response, decode handoff.
// master = fetch_unit side, slave = branch_unit/memory/decode side.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) ();

    logic               branch_taken;
    logic [PC_W-1:0]    target_address;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;

    modport master (
        input  branch_taken, target_address,
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        output branch_taken, target_address,
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH x W FIFO with flush; head visible one cycle after push, zero when empty.
// Push when full is dropped unless a pop frees the slot the same cycle; pop when empty is ignored.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 51
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [W-1:0]            push_data,
    input  logic                    pop,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic [W-1:0]            head,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, response FIFO to decode, branch redirect with drain of wrong-path responses.
// Optional FETCH_PERF_CNT_EN adds saturating pop and flush counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [15:0]  perf_flush_cnt
`endif
);

    localparam int CW = cnt_w(DEPTH);

    fetch_state_t             state;
    logic [PC_W-1:0]          pc;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            discard;
    logic [CW-1:0]            redirect_discard;
    logic [CW-1:0]            fifo_count;
    logic                     live;
    logic                     fifo_empty;
    logic                     credit_ok;
    logic                     req_fire;
    logic                     push;
    logic                     pop;
    logic [PC_W-1:0]          rsp_pc;
    logic [PC_W+INSTR_W-1:0]  head;

    // Buffered plus in-flight fetches never exceed DEPTH, so the FIFO cannot overflow.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

    // live holds requests off for the first cycle after reset.
    assign bus.imem_req_valid   = live && (state == FETCH) && !bus.branch_taken && credit_ok;
    assign bus.imem_addr        = pc;
    assign req_fire             = bus.imem_req_valid && bus.imem_req_ready;

    // In-flight requests are the consecutive PCs just below pc, so the oldest is pc - outstanding.
    assign rsp_pc           = pc - PC_W'(outstanding);
    assign push             = (state == FETCH) && bus.imem_rsp_valid && !bus.branch_taken;
    assign pop              = bus.if_valid && bus.if_ready && !bus.branch_taken;
    assign redirect_discard = outstanding + discard - CW'(bus.imem_rsp_valid);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.branch_taken),
        .push      (push),
        .push_data ({rsp_pc, bus.imem_rsp_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (head),
        .empty     (fifo_empty)
    );

    assign bus.if_valid               = !fifo_empty;
    assign {bus.if_pc, bus.if_instr}  = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            live        <= 1'b0;
        end else begin
            live <= 1'b1;
            if (bus.branch_taken) begin
                pc          <= bus.target_address;
                outstanding <= '0;
                discard     <= redirect_discard;
                state       <= (redirect_discard != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) pc <= pc + 1'b1;
                case (state)
                    FETCH: begin
                        outstanding <= outstanding + CW'(req_fire)
                                       - CW'(bus.imem_rsp_valid && (outstanding != '0));
                    end
                    DRAIN: begin
                        if (bus.imem_rsp_valid) begin
                            discard <= discard - 1'b1;
                            if (discard == CW'(1)) state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.branch_taken && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`else
    // Pop and flush events are not tallied in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for streaming/backpressure, hand sequences for redirect, wrap and reset.
module tb_fetch_unit;

    localparam int PC_W    = 19;
    localparam int INSTR_W = 32;

    typedef struct {
        logic            do_rst;
        logic            rdy;
        logic            rv;
        logic [PC_W-1:0] addr;
        logic            iv;
        logic [PC_W-1:0] pc;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
    } mreq_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   lat;
    int   n_req;
    int   n_rsp;

    mreq_t           mq[$];
    logic [PC_W-1:0] req_log[$];
    logic [PC_W-1:0] dlv[$];
    vec_t            vq[$];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(4), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return 32'h5A00_0000 ^ {13'd0, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock: log handshakes seen before the edge, then present the memory response for the new cycle.
    task automatic tick();
        logic was_rst;
        #1;
        was_rst = rst;
        if (!rst) begin
            if (bus.imem_rsp_valid) begin
                mq.delete(0);
                n_rsp++;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{bus.imem_addr, cyc + lat});
                req_log.push_back(bus.imem_addr);
                n_req++;
            end
            if (bus.if_valid && bus.if_ready && !bus.branch_taken) begin
                chk("dlv_instr", bus.if_instr, instr_of(bus.if_pc));
                dlv.push_back(bus.if_pc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) mq.delete();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(mq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.branch_taken = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [PC_W-1:0] t, input string nm);
        bus.branch_taken   = 1'b1;
        bus.target_address = t;
        #1;
        chk({nm, "_no_req_in_branch"}, bus.imem_req_valid, 0);
        tick();
        bus.branch_taken = 1'b0;
    endtask

    task automatic drain_resume(input int drops, input logic [PC_W-1:0] tgt, input string nm);
        int base_rsp, base_d, stale, rvbad, k;
        base_rsp = n_rsp;
        stale = 0;
        rvbad = 0;
        #1;
        chk({nm, "_flushed"}, bus.if_valid, 0);
        k = 0;
        while (mq.size() > 0 && k < 40) begin
            #1;
            if (bus.imem_req_valid) rvbad++;
            if (bus.if_valid) stale++;
            tick();
            k++;
        end
        chk({nm, "_dropped"}, n_rsp - base_rsp, drops);
        chk({nm, "_req_in_drain"}, rvbad, 0);
        chk({nm, "_stale_valid"}, stale, 0);
        #1;
        chk({nm, "_resume_valid"}, bus.imem_req_valid, 1);
        chk({nm, "_resume_addr"}, bus.imem_addr, tgt);
        base_d = dlv.size();
        k = 0;
        while (dlv.size() == base_d && k < 20) begin
            tick();
            k++;
        end
        chk({nm, "_first_pc"}, (dlv.size() > base_d) ? dlv[base_d] : '1, tgt);
    endtask

    task automatic v(input logic r, input logic rdy, input logic rv, input logic [PC_W-1:0] a,
                     input logic iv, input logic [PC_W-1:0] p);
        vq.push_back('{r, rdy, rv, a, iv, p});
    endtask

    initial begin
        int base, base_d, k;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        lat      = 1;
        n_req    = 0;
        n_rsp    = 0;
        rst                = 1'b1;
        bus.branch_taken   = 1'b0;
        bus.target_address = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;

        // Streaming with 1-cycle memory: {rst, if_ready, req_valid, addr, if_valid, if_pc}
        v(1,1,0,0,0,0); v(0,1,1,0,0,0); v(0,1,1,1,0,0);
        v(0,1,1,2,1,0); v(0,1,1,3,1,1); v(0,1,1,4,1,2);
        // Decode stalled 10 cycles, then released
        v(1,0,0,0,0,0); v(0,0,1,0,0,0); v(0,0,1,1,0,0); v(0,0,1,2,1,0);
        v(0,0,1,3,1,0); v(0,0,0,4,1,0);
        for (int i = 0; i < 5; i++) v(0,0,0,4,1,0);
        v(0,1,0,4,1,0); v(0,1,1,4,1,1); v(0,1,1,5,1,2); v(0,1,1,6,1,3); v(0,1,1,7,1,4);

        foreach (vq[i]) begin
            if (vq[i].do_rst) do_reset();
            bus.if_ready = vq[i].rdy;
            #1;
            chk($sformatf("vec%0d_req_valid", i), bus.imem_req_valid, vq[i].rv);
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, vq[i].addr);
            chk($sformatf("vec%0d_if_valid", i), bus.if_valid, vq[i].iv);
            chk($sformatf("vec%0d_if_pc", i), bus.if_pc, vq[i].iv ? vq[i].pc : '0);
            chk($sformatf("vec%0d_if_instr", i), bus.if_instr,
                vq[i].iv ? instr_of(vq[i].pc) : '0);
            tick();
        end

        // Redirect with one buffered entry and 3 in flight at pc=138
        do_reset();
        bus.if_ready = 1'b0;
        lat = 1;
        redirect(19'd134, "t3_pre");
        base = n_req;
        k = 0;
        while (n_req - base < 4 && k < 20) begin
            if (n_req - base >= 1) lat = 6;
            tick();
            k++;
        end
        #1;
        chk("t3_reqs", n_req - base, 4);
        chk("t3_full_hold_valid", bus.imem_req_valid, 0);
        chk("t3_pc_held", bus.imem_addr, 138);
        chk("t3_buffered_pc", bus.if_pc, 134);
        bus.if_ready = 1'b1;
        redirect(19'd143, "t3");
        drain_resume(3, 19'd143, "t3");
        lat = 1;

        // Redirect coinciding with a response, 2 outstanding
        do_reset();
        bus.if_ready = 1'b1;
        lat = 3;
        base = n_req;
        k = 0;
        while (n_req - base < 2 && k < 20) begin
            tick();
            k++;
        end
        bus.imem_req_ready = 1'b0;
        k = 0;
        while (!bus.imem_rsp_valid && k < 20) begin
            tick();
            k++;
        end
        chk("t4_rsp_present", bus.imem_rsp_valid, 1);
        chk("t4_two_issued", n_req - base, 2);
        bus.imem_req_ready = 1'b1;
        redirect(19'h200, "t4");
        drain_resume(1, 19'h200, "t4");
        lat = 1;

        // PC wrap at 0x7FFFF
        do_reset();
        bus.if_ready = 1'b1;
        redirect(19'h7FFFE, "t5");
        base   = req_log.size();
        base_d = dlv.size();
        k = 0;
        while (dlv.size() - base_d < 3 && k < 20) begin
            tick();
            k++;
        end
        chk("t5_addr0", (req_log.size() > base)     ? req_log[base]     : '0, 19'h7FFFE);
        chk("t5_addr1", (req_log.size() > base + 1) ? req_log[base + 1] : '0, 19'h7FFFF);
        chk("t5_addr2", (req_log.size() > base + 2) ? req_log[base + 2] : '1, 19'h00000);
        chk("t5_dlv_wrap", (dlv.size() > base_d + 2) ? dlv[base_d + 2] : '1, 19'h00000);

        // Reset while draining
        do_reset();
        bus.if_ready = 1'b0;
        lat = 6;
        redirect(19'h40, "t6_pre");
        base = n_req;
        k = 0;
        while (n_req - base < 3 && k < 20) begin
            tick();
            k++;
        end
        redirect(19'h50, "t6");
        #1;
        chk("t6_draining", bus.imem_req_valid, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_flush_cnt_pre", perf_flush_cnt, 2);
`endif
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_req_valid", bus.imem_req_valid, 0);
        chk("t6_rst_if_valid", bus.if_valid, 0);
        chk("t6_rst_if_pc", bus.if_pc, 0);
        chk("t6_rst_if_instr", bus.if_instr, 0);
        chk("t6_rst_pc", bus.imem_addr, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fetch_cnt", perf_fetch_cnt, 0);
        chk("t6_flush_cnt", perf_flush_cnt, 0);
`endif
        tick();
        #1;
        chk("t6_fetch_state_req", bus.imem_req_valid, 1);
        chk("t6_fetch_state_addr", bus.imem_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode and branch_unit.
- Owns the 19-bit PC and issues word-addressed requests to instruction memory.
- Buffers returned instructions, each paired with its PC, in a small FIFO toward decode.
- Redirects to target_address when branch_unit asserts branch_taken, discarding all wrong-path work.

Parameters:
- PC_W, 19, PC/address width (matches branch_unit pc and target_address).
- INSTR_W, 32, instruction word width.
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered fetches (power of 2, ≥2).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- branch_taken  in  1  redirect request from branch_unit.
- target_address  in  PC_W  redirect PC from branch_unit.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  PC_W  fetch word address.
- imem_rsp_valid  in  1  in-order response valid; cannot be back-pressured.
- imem_rsp_data  in  INSTR_W  response instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  INSTR_W  instruction to decode.
- if_pc  out  PC_W  PC of if_instr; drives branch_unit pc downstream.

Behaviour:
- Reset (rst high at a clk edge), next cycle:
  - pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=FETCH.
  - imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0.
- Reset mid-operation aborts everything. Responses arriving after reset for requests issued before it are the memory's responsibility: the memory is reset alongside this block.
- Credit rule: imem_req_valid=1 only when state=FETCH, branch_taken=0, and fifo_count+outstanding < DEPTH.
  - imem_addr=pc.
  - On request handshake: pc<=pc+1, wrapping mod 2^PC_W (0x7FFFF -> 0); outstanding +1.
- Response in FETCH: outstanding −1; {pc_of_req, imem_rsp_data} pushed to FIFO.
  - Request PCs are held in a DEPTH-entry tag queue alongside, or equivalently recomputed.
  - The credit rule guarantees the FIFO never overflows.
- Output: if_valid = FIFO non-empty; if_instr/if_pc come from the head entry.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Empty-FIFO bypass is not allowed: one-cycle minimum latency from response to if_valid.
- States:
  - FETCH: normal operation.
  - DRAIN: discard>0; responses are counted down and dropped; no requests.
- Redirect (branch_taken=1 in any state), next cycle:
  - pc<=target_address; FIFO flushed (if_valid=0).
  - No request is issued in the branch_taken cycle.
  - A pop in the same cycle is ignored.
  - discard <= outstanding + discard − (imem_rsp_valid ? 1 : 0); outstanding <= 0.
  - state <= (new discard>0) ? DRAIN : FETCH.
- DRAIN -> FETCH when the last discarded response arrives. Requests resume the cycle after that.
- A redirect while in DRAIN accumulates per the formula above.
- Back-to-back branch_taken: the last target wins.
- Full: with fifo_count=DEPTH and if_ready=0, no requests and the pc is held.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetch_cnt (32) counting FIFO pops.
  - Adds output perf_flush_cnt (16) counting branch_taken cycles.
  - Both are saturating and reset to 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package/defines file cpu_defs holds:
  - PC_W and INSTR_W defaults.
  - Opcode constants shared with branch_unit (5'b01010, 5'b01011, 5'b01100).
  - State encoding localparams FETCH=1'b0, DRAIN=1'b1.
- Natural sub-module: fetch_fifo.
  - Parameterised DEPTH×(PC_W+INSTR_W) synchronous FIFO.
  - Provides flush, push, pop, count, and head outputs.

Test Plan:
1. Reset, memory 1-cycle latency, if_ready=1 -> imem_addr sequence 0,1,2,3…; if_pc 0,1,2… with matching data; if_valid first rises 2 cycles after the first request.
2. if_ready=0 for 10 cycles -> exactly 4 requests issued (addresses 0–3), then imem_req_valid=0; pc holds 4; releasing if_ready drains in order and fetch resumes at 4.
3. pc at 138, 3 outstanding, branch_taken=1 with target_address=143 (138+5) -> next cycle FIFO empty, state DRAIN, the 3 late responses dropped, next imem_addr=143, next if_pc=143.
4. Redirect in the same cycle as a response, 2 outstanding -> discard=1; only the one remaining response is dropped; no stale instruction reaches decode.
5. pc=0x7FFFF -> following request address 0x00000.
6. rst asserted mid-DRAIN -> next cycle pc=RESET_PC, outputs zero, state FETCH; with FETCH_PERF_CNT_EN, both counters read 0.
